// File: rtl/seg_step_decoder.sv
// Seven-segment bus monitor: glitch-filters the active-low segment pattern, decodes it
// back to a digit and classifies each digit change as step up, step down or illegal jump.
module seg_step_decoder #(
  parameter int MODULUS       = 5,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       clear_err,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       step_up,
  output logic       step_down,
  output logic       err_jump,
  output logic       err_pattern,
  output logic [7:0] net_steps
);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] MAX_DIGIT = 4'(MODULUS - 1);

  state_t     state_reg, state_next;
  logic [6:0] sample_reg, cand_reg, pattern_reg;
  logic [3:0] count_reg, count_next;
  logic       accept_reg, accept_next;
  logic [3:0] digit_reg, digit_next;
  logic       valid_reg, valid_next;
  logic       up_reg, up_next, down_reg, down_next;
  logic       jump_reg, jump_next, pat_err_reg, pat_err_next;
  logic [7:0] net_reg, net_next;

  logic [3:0] pat_value;
  logic       pat_known, pat_blank, pat_legal;
  logic [3:0] digit_inc, digit_dec;

  // Count saturates at STABLE so a long stable run is accepted exactly once.
  always_comb begin
    count_next = count_reg;
    if (sample_reg != cand_reg)
      count_next = 4'd1;
    else if (count_reg < STABLE)
      count_next = count_reg + 4'd1;
    accept_next = (count_next == STABLE) && ((sample_reg != cand_reg) || (count_reg != STABLE));
  end

  always_comb begin
    pat_value = 4'd0;
    pat_known = 1'b1;
    pat_blank = 1'b0;
    case (pattern_reg)
      7'b1000000: pat_value = 4'd0;
      7'b1111001: pat_value = 4'd1;
      7'b0100100: pat_value = 4'd2;
      7'b0110000: pat_value = 4'd3;
      7'b0011001: pat_value = 4'd4;
      7'b0010010: pat_value = 4'd5;
      7'b0000010: pat_value = 4'd6;
      7'b1111000: pat_value = 4'd7;
      7'b0000000: pat_value = 4'd8;
      7'b0010000: pat_value = 4'd9;
      7'b1111111: begin pat_known = 1'b0; pat_blank = 1'b1; end
      default:    pat_known = 1'b0;
    endcase
    pat_legal = pat_known && (pat_value <= MAX_DIGIT);
    digit_inc = (digit_reg == MAX_DIGIT) ? 4'd0 : digit_reg + 4'd1;
    digit_dec = (digit_reg == 4'd0) ? MAX_DIGIT : digit_reg - 4'd1;
  end

  always_comb begin
    state_next   = state_reg;
    digit_next   = digit_reg;
    valid_next   = valid_reg;
    up_next      = 1'b0;
    down_next    = 1'b0;
    net_next     = net_reg;
    jump_next    = clear_err ? 1'b0 : jump_reg;
    pat_err_next = clear_err ? 1'b0 : pat_err_reg;
    if (accept_reg) begin
      case (state_reg)
        ST_TRACK: begin
          if (pat_legal) begin
            if (pat_value != digit_reg) begin
              // Up is tested first so MODULUS==2 reports every change as a step up.
              if (pat_value == digit_inc) begin
                up_next  = 1'b1;
                net_next = net_reg + 8'd1;
              end else if (pat_value == digit_dec) begin
                down_next = 1'b1;
                net_next  = net_reg - 8'd1;
              end else begin
                jump_next = 1'b1;
              end
            end
            digit_next = pat_value;
          end else if (pat_blank) begin
            state_next = ST_INIT;
            valid_next = 1'b0;
          end else begin
            state_next   = ST_FAULT;
            valid_next   = 1'b0;
            pat_err_next = 1'b1;
          end
        end
        ST_FAULT: begin
          if (pat_legal) begin
            state_next = ST_TRACK;
            digit_next = pat_value;
            valid_next = 1'b1;
          end else if (pat_blank) begin
            state_next = ST_INIT;
          end
        end
        default: begin
          if (pat_legal) begin
            state_next = ST_TRACK;
            digit_next = pat_value;
            valid_next = 1'b1;
          end else if (!pat_blank) begin
            state_next   = ST_FAULT;
            valid_next   = 1'b0;
            pat_err_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_reg  <= 7'h7F;
      cand_reg    <= 7'h7F;
      pattern_reg <= 7'h7F;
      count_reg   <= 4'd0;
      accept_reg  <= 1'b0;
      state_reg   <= ST_INIT;
      digit_reg   <= 4'd0;
      valid_reg   <= 1'b0;
      up_reg      <= 1'b0;
      down_reg    <= 1'b0;
      jump_reg    <= 1'b0;
      pat_err_reg <= 1'b0;
      net_reg     <= 8'd0;
    end else begin
      sample_reg  <= seg_in;
      cand_reg    <= sample_reg;
      pattern_reg <= sample_reg;
      count_reg   <= count_next;
      accept_reg  <= accept_next;
      state_reg   <= state_next;
      digit_reg   <= digit_next;
      valid_reg   <= valid_next;
      up_reg      <= up_next;
      down_reg    <= down_next;
      jump_reg    <= jump_next;
      pat_err_reg <= pat_err_next;
      net_reg     <= net_next;
    end
  end

  assign digit       = digit_reg;
  assign digit_valid = valid_reg;
  assign step_up     = up_reg;
  assign step_down   = down_reg;
  assign err_jump    = jump_reg;
  assign err_pattern = pat_err_reg;
  assign net_steps   = net_reg;

endmodule

// File: tb/tb_seg_step_decoder.sv
// Directed bench for seg_step_decoder (MODULUS=5, STABLE_CYCLES=2); inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_seg_step_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       clear_err;
  logic [3:0] digit;
  logic       digit_valid, step_up, step_down, err_jump, err_pattern;
  logic [7:0] net_steps;

  int checks = 0;
  int failures = 0;
  int up_cnt = 0;
  int down_cnt = 0;
  int both_cnt = 0;

  logic [6:0] seg_tab [0:9];

  always #5 clk = ~clk;

  seg_step_decoder #(.MODULUS(5), .STABLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear_err(clear_err),
    .digit(digit), .digit_valid(digit_valid), .step_up(step_up), .step_down(step_down),
    .err_jump(err_jump), .err_pattern(err_pattern), .net_steps(net_steps)
  );

  // Pulse monitor: sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (step_up) up_cnt++;
    if (step_down) down_cnt++;
    if (step_up && step_down) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, actual);
    end
  endtask

  // Called on a falling edge; drives the pattern and waits n falling edges.
  task automatic apply(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    seg_in = 7'h7F;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    up_cnt = 0;
    down_cnt = 0;
    reset = 1'b1;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    // 1: reset values, then first digit appears three edges after it is first sampled
    reset = 1'b0;
    seg_in = 7'h7F;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_errs", 32'({err_jump, err_pattern}), 32'd0);
    check("rst_net", 32'(net_steps), 32'd0);
    reset = 1'b1;
    up_cnt = 0;
    down_cnt = 0;
    apply(seg_tab[0], 3);
    check("lat_not_yet_valid", 32'(digit_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(digit_valid), 32'd1);
    check("first_digit", 32'(digit), 32'd0);
    check("first_net", 32'(net_steps), 32'd0);
    check("first_no_pulse", 32'(up_cnt + down_cnt), 32'd0);

    // 2: 0,1,2,3,4,0 -> five step ups including the 4->0 wrap
    apply(seg_tab[0], 2);
    for (int i = 1; i <= 5; i++) apply(seg_tab[i % 5], 5);
    check("seq_up_pulses", 32'(up_cnt), 32'd5);
    check("seq_down_pulses", 32'(down_cnt), 32'd0);
    check("seq_net", 32'(net_steps), 32'h05);
    check("seq_digit", 32'(digit), 32'd0);
    check("seq_no_errs", 32'({err_jump, err_pattern}), 32'd0);

    // 3: from a fresh 0, 0->4 is a step down
    do_reset();
    apply(seg_tab[0], 5);
    apply(seg_tab[4], 5);
    check("wrap_down_pulses", 32'(down_cnt), 32'd1);
    check("wrap_down_up_pulses", 32'(up_cnt), 32'd0);
    check("wrap_down_net", 32'(net_steps), 32'hFF);
    check("wrap_down_digit", 32'(digit), 32'd4);

    // net_steps positive overflow: 4 ->0 brings net to 0, then 127 more ups, then one more
    apply(seg_tab[0], 4);
    check("net_back_zero", 32'(net_steps), 32'h00);
    for (int i = 1; i <= 127; i++) apply(seg_tab[i % 5], 4);
    check("net_7f", 32'(net_steps), 32'h7F);
    apply(seg_tab[3], 4);
    check("net_wrap_80", 32'(net_steps), 32'h80);
    check("never_both", 32'(both_cnt), 32'd0);

    // 4: one-cycle glitch is rejected
    do_reset();
    apply(seg_tab[0], 5);
    apply(seg_tab[1], 1);
    apply(seg_tab[0], 6);
    check("glitch_pulses", 32'(up_cnt + down_cnt), 32'd0);
    check("glitch_digit", 32'(digit), 32'd0);
    check("glitch_valid", 32'(digit_valid), 32'd1);

    // 5: 0->2 is an illegal jump; clear_err removes it
    apply(seg_tab[2], 5);
    check("jump_err", 32'(err_jump), 32'd1);
    check("jump_digit", 32'(digit), 32'd2);
    check("jump_no_pulse", 32'(up_cnt + down_cnt), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("jump_cleared", 32'(err_jump), 32'd0);

    // 6: digit 5 is illegal for MODULUS 5, recovery to 3 without a step
    apply(seg_tab[5], 5);
    check("pat_err", 32'(err_pattern), 32'd1);
    check("pat_valid_low", 32'(digit_valid), 32'd0);
    apply(seg_tab[3], 5);
    check("recover_digit", 32'(digit), 32'd3);
    check("recover_valid", 32'(digit_valid), 32'd1);
    check("recover_no_pulse", 32'(up_cnt + down_cnt), 32'd0);
    check("pat_err_sticky", 32'(err_pattern), 32'd1);

    // Blank returns to INIT and drops valid while digit holds
    apply(7'h7F, 5);
    check("blank_valid", 32'(digit_valid), 32'd0);
    check("blank_digit_hold", 32'(digit), 32'd3);

    // Asynchronous reset in the middle of filtering
    apply(seg_tab[4], 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_outputs",
          32'({digit, digit_valid, step_up, step_down, err_jump, err_pattern, net_steps}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
